// File: rtl/mem_arbiter.sv
// Main-memory arbiter between the I-cache and D-cache controllers.
// Runs 8-word block fills for either cache and single-word writes for the
// D-cache, one transaction at a time, with D requests winning ties.
module mem_arbiter #(
    parameter int MEM_LAT       = 4,
    parameter int WORDS_PER_BLK = 8,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    // I-cache side
    input  logic                             i_req,
    input  logic [ADDR_W-1:0]                i_addr,
    output logic                             i_fill_valid,
    output logic [$clog2(WORDS_PER_BLK)-1:0] i_fill_idx,
    output logic                             i_done,
    // D-cache side
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [ADDR_W-1:0]                d_addr,
    input  logic [DATA_W-1:0]                d_wdata,
    output logic                             d_fill_valid,
    output logic [$clog2(WORDS_PER_BLK)-1:0] d_fill_idx,
    output logic                             d_done,
    // shared fill bus
    output logic [DATA_W-1:0]                fill_data,
    // memory side
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_rvalid,
    output logic                             busy
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    // Byte-offset bits inside one block (2 bytes per word).
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * WORDS_PER_BLK - 1);
    localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;      // 1 = D-cache owns the transaction
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    // One extra bit: MSB set means all reads of the block have been issued.
    logic [IDX_W:0]      issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [LAT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   fill_off;

    assign base_addr = addr_q & ~BLK_MASK;
    assign fill_off  = ADDR_W'({issue_cnt_q[IDX_W-1:0], 1'b0});

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state and output decode; fill returns pass straight through to the owner.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        i_fill_valid = 1'b0;
        i_fill_idx   = '0;
        i_done       = 1'b0;
        d_fill_valid = 1'b0;
        d_fill_idx   = '0;
        d_done       = 1'b0;
        fill_data    = '0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy        = 1'b0;
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                wait_cnt_d  = '0;
                // D first: its miss belongs to the older instruction.
                if (d_req) begin
                    owner_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = d_we ? S_WRITE : S_FILL;
                end else if (i_req) begin
                    owner_d = 1'b0;
                    addr_d  = i_addr;
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                if (!issue_cnt_q[IDX_W]) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_addr | fill_off;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_rvalid) begin
                    fill_data    = mem_rdata;
                    i_fill_valid = !owner_q;
                    d_fill_valid = owner_q;
                    i_fill_idx   = owner_q ? '0 : ret_cnt_q;
                    d_fill_idx   = owner_q ? ret_cnt_q : '0;
                    ret_cnt_d    = ret_cnt_q + 1'b1;
                    if (&ret_cnt_q)
                        state_d = S_DONE;
                end
            end

            S_WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q & ~BYTE_MASK;
                mem_wdata  = wdata_q;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (wait_cnt_q == LAT_LAST)
                    state_d = S_DONE;
                else
                    wait_cnt_d = wait_cnt_q + 1'b1;
            end

            S_DONE: begin
                i_done  = !owner_q;
                d_done  = owner_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
